// File: rtl/morse_encoder_tx.sv
// Morse keying transmitter: one character code in, ITU-timed key_out.
// Dot = 1 unit, dash = 3, element gap 1, char gap 3, word space +4.
module morse_encoder_tx #(
  parameter int UNIT_CYCLES = 2_400_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       elem_dash,
  output logic       busy,
  output logic       char_done,
  output logic       bad_char
);

  localparam int CW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(UNIT_CYCLES - 2);
  localparam logic [5:0] WORD_SP = 6'd36;

  typedef enum logic [2:0] {
    IDLE, ELEM, EGAP, CGAP, WSPACE
  } state_t;

  state_t      state;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]  unit_cnt;
  logic [2:0]  elem_idx;
  logic [2:0]  len_q;
  logic [4:0]  pat_q;
  logic [2:0]  rom_len;
  logic [4:0]  rom_pat;
  logic        unit_end;
  logic        state_end;

  assign char_ready = (state == IDLE);
  assign unit_end   = (cyc_cnt == LAST);
  assign state_end  = unit_end && (unit_cnt == 3'd0);

  // Pattern ROM: first element in bit 0, 1 = dash; len 0 marks invalid.
  always_comb begin
    rom_len = 3'd0;
    rom_pat = 5'b00000;
    case (char_in)
      6'd0:  begin rom_len = 3'd2; rom_pat = 5'b00010; end
      6'd1:  begin rom_len = 3'd4; rom_pat = 5'b00001; end
      6'd2:  begin rom_len = 3'd4; rom_pat = 5'b00101; end
      6'd3:  begin rom_len = 3'd3; rom_pat = 5'b00001; end
      6'd4:  begin rom_len = 3'd1; rom_pat = 5'b00000; end
      6'd5:  begin rom_len = 3'd4; rom_pat = 5'b00100; end
      6'd6:  begin rom_len = 3'd3; rom_pat = 5'b00011; end
      6'd7:  begin rom_len = 3'd4; rom_pat = 5'b00000; end
      6'd8:  begin rom_len = 3'd2; rom_pat = 5'b00000; end
      6'd9:  begin rom_len = 3'd4; rom_pat = 5'b01110; end
      6'd10: begin rom_len = 3'd3; rom_pat = 5'b00101; end
      6'd11: begin rom_len = 3'd4; rom_pat = 5'b00010; end
      6'd12: begin rom_len = 3'd2; rom_pat = 5'b00011; end
      6'd13: begin rom_len = 3'd2; rom_pat = 5'b00001; end
      6'd14: begin rom_len = 3'd3; rom_pat = 5'b00111; end
      6'd15: begin rom_len = 3'd4; rom_pat = 5'b00110; end
      6'd16: begin rom_len = 3'd4; rom_pat = 5'b01011; end
      6'd17: begin rom_len = 3'd3; rom_pat = 5'b00010; end
      6'd18: begin rom_len = 3'd3; rom_pat = 5'b00000; end
      6'd19: begin rom_len = 3'd1; rom_pat = 5'b00001; end
      6'd20: begin rom_len = 3'd3; rom_pat = 5'b00100; end
      6'd21: begin rom_len = 3'd4; rom_pat = 5'b01000; end
      6'd22: begin rom_len = 3'd3; rom_pat = 5'b00110; end
      6'd23: begin rom_len = 3'd4; rom_pat = 5'b01001; end
      6'd24: begin rom_len = 3'd4; rom_pat = 5'b01101; end
      6'd25: begin rom_len = 3'd4; rom_pat = 5'b00011; end
      6'd26: begin rom_len = 3'd5; rom_pat = 5'b11111; end
      6'd27: begin rom_len = 3'd5; rom_pat = 5'b11110; end
      6'd28: begin rom_len = 3'd5; rom_pat = 5'b11100; end
      6'd29: begin rom_len = 3'd5; rom_pat = 5'b11000; end
      6'd30: begin rom_len = 3'd5; rom_pat = 5'b10000; end
      6'd31: begin rom_len = 3'd5; rom_pat = 5'b00000; end
      6'd32: begin rom_len = 3'd5; rom_pat = 5'b00001; end
      6'd33: begin rom_len = 3'd5; rom_pat = 5'b00011; end
      6'd34: begin rom_len = 3'd5; rom_pat = 5'b00111; end
      6'd35: begin rom_len = 3'd5; rom_pat = 5'b01111; end
      default: begin rom_len = 3'd0; rom_pat = 5'b00000; end
    endcase
  end

  // Keying FSM with unit timing counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      unit_cnt  <= 3'd0;
      elem_idx  <= 3'd0;
      len_q     <= 3'd0;
      pat_q     <= 5'b00000;
      key_out   <= 1'b0;
      elem_dash <= 1'b0;
      busy      <= 1'b0;
      char_done <= 1'b0;
      bad_char  <= 1'b0;
    end else begin
      char_done <= 1'b0;
      bad_char  <= 1'b0;
      case (state)
        IDLE: begin
          cyc_cnt  <= '0;
          unit_cnt <= 3'd0;
          elem_idx <= 3'd0;
          if (char_valid) begin
            if (char_in == WORD_SP) begin
              state    <= WSPACE;
              unit_cnt <= 3'd3;
              busy     <= 1'b1;
            end else if (rom_len != 3'd0) begin
              state     <= ELEM;
              pat_q     <= rom_pat;
              len_q     <= rom_len;
              unit_cnt  <= rom_pat[0] ? 3'd2 : 3'd0;
              key_out   <= 1'b1;
              elem_dash <= rom_pat[0];
              busy      <= 1'b1;
            end else begin
              bad_char <= 1'b1;
            end
          end
        end
        default: begin
          if (unit_end) begin
            cyc_cnt <= '0;
            if (unit_cnt != 3'd0)
              unit_cnt <= unit_cnt - 3'd1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
          if ((state == CGAP || state == WSPACE) &&
              unit_cnt == 3'd0 && cyc_cnt == PRE)
            char_done <= 1'b1;
          if (state_end) begin
            case (state)
              ELEM: begin
                key_out   <= 1'b0;
                elem_dash <= 1'b0;
                if ((elem_idx + 3'd1) < len_q) begin
                  state    <= EGAP;
                  unit_cnt <= 3'd0;
                  elem_idx <= elem_idx + 3'd1;
                end else begin
                  state    <= CGAP;
                  unit_cnt <= 3'd2;
                end
              end
              EGAP: begin
                state     <= ELEM;
                unit_cnt  <= pat_q[elem_idx] ? 3'd2 : 3'd0;
                key_out   <= 1'b1;
                elem_dash <= pat_q[elem_idx];
              end
              default: begin
                state    <= IDLE;
                unit_cnt <= 3'd0;
                elem_idx <= 3'd0;
                busy     <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Bench for morse_encoder_tx: directed cases plus random codes
// compared cycle by cycle against a dot/dash string reference.
module tb_morse_encoder_tx;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       key_out;
  logic       elem_dash;
  logic       busy;
  logic       char_done;
  logic       bad_char;

  int n_cmp = 0;
  int n_err = 0;

  string morse [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
    "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
    "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
    "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  morse_encoder_tx #(.UNIT_CYCLES(U)) dut (
    .clk(clk),
    .rst(rst),
    .char_in(char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .key_out(key_out),
    .elem_dash(elem_dash),
    .busy(busy),
    .char_done(char_done),
    .bad_char(bad_char)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accept code at the next edge, then check every cycle of it.
  task automatic run_char(input int code, input bit hold_e);
    bit    kq[$];
    bit    dq[$];
    string s;
    int    total;
    bit    dsh;
    char_in    = 6'(code);
    char_valid = 1'b1;
    chk($sformatf("c%0d ready", code), char_ready, 1);
    @(posedge clk);
    #1;
    if (hold_e) begin
      char_in    = 6'd4;
      char_valid = 1'b1;
    end else begin
      char_valid = 1'b0;
    end
    kq = {};
    dq = {};
    if (code == 36) begin
      repeat (4 * U) begin kq.push_back(0); dq.push_back(0); end
    end else begin
      s = morse[code];
      for (int i = 0; i < s.len(); i++) begin
        dsh = (s[i] == 8'h2D);
        repeat ((dsh ? 3 : 1) * U) begin
          kq.push_back(1);
          dq.push_back(dsh);
        end
        if (i < s.len() - 1)
          repeat (U) begin kq.push_back(0); dq.push_back(0); end
      end
      repeat (3 * U) begin kq.push_back(0); dq.push_back(0); end
    end
    total = kq.size();
    for (int n = 1; n <= total; n++) begin
      @(negedge clk);
      chk($sformatf("c%0d key n%0d", code, n), key_out, kq[n-1]);
      chk($sformatf("c%0d dash n%0d", code, n), elem_dash, dq[n-1]);
      chk($sformatf("c%0d done n%0d", code, n), char_done, n == total);
      chk($sformatf("c%0d busy n%0d", code, n), busy, 1);
      chk($sformatf("c%0d rdy n%0d", code, n), char_ready, 0);
    end
    @(negedge clk);
    chk($sformatf("c%0d rdy end", code), char_ready, 1);
    chk($sformatf("c%0d busy end", code), busy, 0);
    chk($sformatf("c%0d done end", code), char_done, 0);
    chk($sformatf("c%0d key end", code), key_out, 0);
  endtask

  task automatic bad_code(input int code);
    char_in    = 6'(code);
    char_valid = 1'b1;
    chk("bad ready", char_ready, 1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("bad%0d pulse", code), bad_char, 1);
    chk("bad busy", busy, 0);
    chk("bad key", key_out, 0);
    chk("bad ready1", char_ready, 1);
    @(negedge clk);
    chk("bad pulse off", bad_char, 0);
    chk("bad ready2", char_ready, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle key", key_out, 0);
      chk("idle busy", busy, 0);
      chk("idle done", char_done, 0);
    end
  endtask

  initial begin
    int code;
    rst        = 1'b1;
    char_valid = 1'b1;
    char_in    = 6'd4;
    repeat (3) @(posedge clk);
    #1;
    rst        = 1'b0;
    char_valid = 1'b0;
    @(negedge clk);
    chk("rst key", key_out, 0);
    chk("rst dash", elem_dash, 0);
    chk("rst busy", busy, 0);
    chk("rst done", char_done, 0);
    chk("rst bad", bad_char, 0);
    chk("rst ready", char_ready, 1);

    run_char(4, 0);
    run_char(0, 0);
    run_char(26, 1);
    run_char(4, 0);
    run_char(19, 0);
    run_char(36, 0);
    bad_code(50);
    run_char(18, 0);

    char_in    = 6'd19;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      chk($sformatf("mid key n%0d", n), key_out, 1);
      chk($sformatf("mid dash n%0d", n), elem_dash, 1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst key", key_out, 0);
    chk("mid rst dash", elem_dash, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst ready", char_ready, 1);
    chk("mid rst done", char_done, 0);
    idle(30);
    run_char(4, 0);

    for (int r = 0; r < 25; r++) begin
      code = $urandom_range(0, 40);
      if (code > 36)
        bad_code(37 + $urandom_range(0, 26));
      else
        run_char(code, 0);
      idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
